// File: rtl/iir_output_capture_pkg.sv
// Shared FSM encoding and default widths for the IIR output capture block.
package iir_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_DONE    = 2'b10
    } state_t;

    localparam int DEF_DATA_W = 11;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/iir_output_capture_if.sv
// Host/filter-facing signal bundle of the capture block; slave is the DUT side.
interface iir_output_capture_if #(
    parameter int DATA_W = 11,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              vin;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic [CNT_W-1:0]  captured;

    modport slave (
        input  start, len, vin, din, rd_en,
        output rd_valid, rd_data, busy, done, empty, full, level, overflow, captured
    );

    modport master (
        output start, len, vin, din, rd_en,
        input  rd_valid, rd_data, busy, done, empty, full, level, overflow, captured
    );
endinterface

// File: rtl/iir_output_capture_fifo.sv
// Circular-buffer FIFO with registered read port; push into a full FIFO is
// accepted only when a pop frees the head in the same cycle.
module capture_fifo #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level
);
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_do_pop;
    logic              w_do_push;

    assign o_full     = (r_level == FULL_LEVEL);
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

    // A pop on an empty FIFO never sees same-cycle push data.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_do_pop;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/iir_output_capture.sv
// Captures a programmed number of filter output samples into a FIFO for host
// readout, tracking accepted samples and a sticky overflow flag.
module iir_output_capture
    import iir_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    iir_output_capture_if.slave   bus
);
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_captured;
    logic [CNT_W-1:0] w_captured_inc;
    logic             r_overflow;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_arm;
    logic             w_zero_start;
    logic             w_full;
    logic             w_empty;

    assign w_pop          = bus.rd_en && !w_empty;
    assign w_captured_inc = r_captured + CNT_W'(1);

    // captured counts dropped samples too, so reaching len ends the capture
    // regardless of FIFO space and the counter can never pass len.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        w_arm        = 1'b0;
        w_zero_start = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        w_arm        = 1'b1;
                        w_state_next = ST_CAPTURE;
                    end else begin
                        w_zero_start = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (bus.vin) begin
                    if (!w_full || w_pop) begin
                        w_push = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                    if (w_captured_inc == r_len) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= '0;
            r_captured <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_arm) begin
                r_len <= bus.len;
            end
            if (w_arm || w_zero_start) begin
                r_captured <= '0;
            end else if (r_state == ST_CAPTURE && bus.vin) begin
                r_captured <= w_captured_inc;
            end
            if (w_arm) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    capture_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_din      (bus.din),
        .i_pop      (w_pop),
        .o_rd_valid (bus.rd_valid),
        .o_rd_data  (bus.rd_data),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (bus.level)
    );

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.busy     = (r_state == ST_CAPTURE);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.overflow = r_overflow;
    assign bus.captured = r_captured;

endmodule
